seq_detect_ctrl: RTL and testbench

//  Sequencer for the serial pattern detector. Accepts a parallel word, feeds its

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/seq_window_cmp.sv | 62 ++++++
 rtl/seq_detect_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detector sequencer.
// Overlapping detections are enabled by defining DETECT_OVERLAP_EN.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         PAT_LEN_V12 = 7;
  localparam logic [6:0] PATTERN_V12 = 7'b1100111;

  // Width of a bit index within a word of word_w bits.
  function automatic int idx_w(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

  // Width of a counter that must reach the value max_val.
  function automatic int cnt_w_for(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Sliding window, fill counter and pattern comparator for the detector.
// DETECT_OVERLAP_EN selects whether the window survives a detection.
import seq_detect_pkg::*;

module seq_window_cmp #(
  parameter int                   PAT_LEN = PAT_LEN_V12,
  parameter logic [PAT_LEN-1:0]   PATTERN = PATTERN_V12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic               bit_in_i,
  output logic [PAT_LEN-1:0] win_o,
  output logic               hit_o
);

  localparam int                FILL_W   = cnt_w_for(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] win_q, win_d, win_base;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_base;
  logic               hit_q;

  always_comb begin
    win_base  = win_q;
    fill_base = fill_q;
`ifndef DETECT_OVERLAP_EN
    // Without overlap, the bit after a detection starts a fresh window.
    if (hit_q) begin
      win_base  = '0;
      fill_base = '0;
    end
`endif
    win_d  = win_q;
    fill_d = fill_q;
    if (shift_en_i) begin
      win_d  = {win_base[PAT_LEN-2:0], bit_in_i};
      fill_d = (fill_base == FILL_MAX) ? fill_base : fill_base + 1'b1;
    end
    hit_o = shift_en_i && (win_d == PATTERN) && (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q  <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else if (clr_i) begin
      win_q  <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else if (shift_en_i) begin
      win_q  <= win_d;
      fill_q <= fill_d;
      hit_q  <= hit_o;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run sequencer: loads a word, feeds it MSB-first into the window comparator
// and reports detections, a saturating count and a done pulse. Macro: DETECT_OVERLAP_EN.
//
//   state | meaning
//   IDLE  | waiting for start; results of the last run held
//   SHIFT | feeding one bit per clock into the window
//   DONE  | run finished; done pulses on the way back to IDLE
import seq_detect_pkg::*;

module seq_detect_ctrl #(
  parameter int                 WORD_W  = 16,
  parameter int                 PAT_LEN = PAT_LEN_V12,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_V12,
  parameter int                 CNT_W   = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      start,
  input  logic [WORD_W-1:0]         word,
  input  logic [$clog2(WORD_W):0]   nbits,
  output logic                      busy,
  output logic                      done,
  output logic                      match,
  output logic [$clog2(WORD_W)-1:0] match_pos,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      bit_out,
  output logic [PAT_LEN-1:0]        win
);

  localparam int               IDX_W   = idx_w(WORD_W);
  localparam int               NB_W    = $clog2(WORD_W) + 1;
  localparam logic [NB_W-1:0]  NB_MAX  = NB_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [NB_W-1:0]   rem_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  pos_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q, match_q, bit_q;

  logic [NB_W-1:0]   n_clamp;
  logic              accept, shift_en, hit;

  assign n_clamp  = (nbits > NB_MAX) ? NB_MAX : nbits;
  assign accept   = (state_q == IDLE) && start;
  assign shift_en = (state_q == SHIFT);

  seq_window_cmp #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_win (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET),
    .clr_i      (accept),
    .shift_en_i (shift_en),
    .bit_in_i   (sreg_q[WORD_W-1]),
    .win_o      (win),
    .hit_o      (hit)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      match_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sreg_q  <= word;
            rem_q   <= n_clamp;
            idx_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (n_clamp == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          sreg_q <= {sreg_q[WORD_W-2:0], 1'b0};
          bit_q  <= sreg_q[WORD_W-1];
          idx_q  <= idx_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (hit) begin
            match_q <= 1'b1;
            pos_q   <= idx_q;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          end
          if (rem_q == NB_W'(1)) state_q <= DONE;
        end
        DONE: begin
          // done rises as the FSM returns to IDLE, one edge after the last match.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;
  assign match_pos = pos_q;
  assign match_cnt = cnt_q;
  assign bit_out   = bit_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; expectations follow DETECT_OVERLAP_EN.
module tb_seq_detect_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic        start    = 1'b0;
  logic [15:0] word     = '0;
  logic [4:0]  nbits    = '0;

  logic       busy, done, match, bit_out;
  logic [3:0] match_pos, match_cnt;
  logic [6:0] win;

  logic       s_busy, s_done, s_match, s_bit_out;
  logic [3:0] s_match_pos;
  logic [0:0] s_match_cnt;
  logic [6:0] s_win;

  int total = 0;
  int bad   = 0;
  int r_lat, r_matches, r_pos, r_coinc, r_busy_gap;

  seq_detect_ctrl #(.WORD_W(16), .PAT_LEN(7), .PATTERN(7'b1100111), .CNT_W(4)) dut (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .start (start), .word (word), .nbits (nbits),
    .busy (busy), .done (done), .match (match), .match_pos (match_pos),
    .match_cnt (match_cnt), .bit_out (bit_out), .win (win)
  );

  seq_detect_ctrl #(.WORD_W(16), .PAT_LEN(7), .PATTERN(7'b1100111), .CNT_W(1)) dut_sat (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .start (start), .word (word), .nbits (nbits),
    .busy (s_busy), .done (s_done), .match (s_match), .match_pos (s_match_pos),
    .match_cnt (s_match_cnt), .bit_out (s_bit_out), .win (s_win)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Starts a run and samples every cycle until done (bounded at 40 edges).
  // inject_at > 0 pulses a conflicting start after that many edges.
  task automatic do_run(input logic [15:0] w, input logic [4:0] nb, input int inject_at);
    r_lat = -1; r_matches = 0; r_pos = -1; r_coinc = 0; r_busy_gap = 0;
    word = w; nbits = nb; start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLOCK_50); #1;
      if (k == inject_at) begin
        start = 1'b1; word = '0; nbits = '0;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      if (match) begin
        r_matches++;
        r_pos = int'(match_pos);
      end
      if (match && done) r_coinc++;
      if (done) begin
        r_lat = k;
        break;
      end
      if (!busy) r_busy_gap++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #5;
    total++;
    if ({busy, done, match, bit_out, win, match_pos, match_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {busy, done, match, bit_out, win, match_pos, match_cnt});
    end
    total++;
    if ({s_busy, s_done, s_match, s_bit_out, s_win, s_match_pos, s_match_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_sat got=%b want=0", {s_busy, s_done, s_match, s_bit_out, s_win, s_match_pos, s_match_cnt});
    end
    #20 RESET = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_single_hit;
    do_run(16'h0067, 5'd16, -1);
    total++; if (r_lat !== 17) begin bad++; $display("FAIL single_latency got=%0d want=17", r_lat); end
    total++; if (r_matches !== 1) begin bad++; $display("FAIL single_matches got=%0d want=1", r_matches); end
    total++; if (match_pos !== 4'd15) begin bad++; $display("FAIL single_pos got=%0d want=15", match_pos); end
    total++; if (match_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", match_cnt); end
    total++; if (win !== 7'b1100111) begin bad++; $display("FAIL single_win got=%b want=1100111", win); end
    total++; if (bit_out !== 1'b1) begin bad++; $display("FAIL single_bit_out got=%b want=1", bit_out); end
    total++; if (r_coinc !== 0) begin bad++; $display("FAIL single_done_match_overlap got=%0d want=0", r_coinc); end
    total++; if (r_busy_gap !== 0) begin bad++; $display("FAIL single_busy_gap got=%0d want=0", r_busy_gap); end
    @(posedge CLOCK_50); #1;
    total++; if (win !== 7'b1100111 || match_cnt !== 4'd1) begin
      bad++; $display("FAIL single_idle_hold got win=%b cnt=%0d want 1100111/1", win, match_cnt);
    end
  endtask

  task automatic test_overlap;
    int exp_m, exp_pos;
`ifdef DETECT_OVERLAP_EN
    exp_m = 2; exp_pos = 11;
`else
    exp_m = 1; exp_pos = 6;
`endif
    do_run(16'b1100_1110_0111_0000, 5'd12, -1);
    total++; if (r_lat !== 13) begin bad++; $display("FAIL overlap_latency got=%0d want=13", r_lat); end
    total++; if (r_matches !== exp_m) begin bad++; $display("FAIL overlap_matches got=%0d want=%0d", r_matches, exp_m); end
    total++; if (r_pos !== exp_pos) begin bad++; $display("FAIL overlap_last_pos got=%0d want=%0d", r_pos, exp_pos); end
    total++; if (int'(match_cnt) !== exp_m) begin bad++; $display("FAIL overlap_cnt got=%0d want=%0d", match_cnt, exp_m); end
  endtask

  task automatic test_boundaries;
    do_run(16'hFFFF, 5'd0, -1);
    total++; if (r_lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", r_lat); end
    total++; if (r_matches !== 0) begin bad++; $display("FAIL zero_matches got=%0d want=0", r_matches); end
    total++; if (match_cnt !== 4'd0 || win !== 7'd0) begin
      bad++; $display("FAIL zero_cleared got cnt=%0d win=%b want 0/0000000", match_cnt, win);
    end
    do_run(16'h0067, 5'd20, -1);
    total++; if (r_lat !== 17) begin bad++; $display("FAIL clamp_latency got=%0d want=17", r_lat); end
    total++; if (r_pos !== 15 || match_cnt !== 4'd1) begin
      bad++; $display("FAIL clamp_result got pos=%0d cnt=%0d want 15/1", r_pos, match_cnt);
    end
    do_run(16'b1100_1110_0000_0000, 5'd6, -1);
    total++; if (r_lat !== 7) begin bad++; $display("FAIL short_latency got=%0d want=7", r_lat); end
    total++; if (r_matches !== 0 || match_cnt !== 4'd0) begin
      bad++; $display("FAIL short_nomatch got m=%0d cnt=%0d want 0/0", r_matches, match_cnt);
    end
    total++; if (win !== 7'b0110011) begin bad++; $display("FAIL short_win got=%b want=0110011", win); end
  endtask

  task automatic test_saturation;
    // Two back-to-back patterns detected at 6 and 13 in either overlap mode.
    do_run(16'hCF9C, 5'd16, -1);
    total++; if (r_matches !== 2) begin bad++; $display("FAIL sat_matches got=%0d want=2", r_matches); end
    total++; if (r_pos !== 13) begin bad++; $display("FAIL sat_pos got=%0d want=13", r_pos); end
    total++; if (match_cnt !== 4'd2) begin bad++; $display("FAIL sat_cnt_wide got=%0d want=2", match_cnt); end
    total++; if (s_match_cnt !== 1'b1) begin bad++; $display("FAIL sat_cnt_narrow got=%0d want=1", s_match_cnt); end
  endtask

  task automatic test_busy_start;
    do_run(16'h0067, 5'd16, 3);
    total++; if (r_lat !== 17) begin bad++; $display("FAIL busy_start_latency got=%0d want=17", r_lat); end
    total++; if (r_matches !== 1 || r_pos !== 15 || match_cnt !== 4'd1) begin
      bad++; $display("FAIL busy_start_result got m=%0d pos=%0d cnt=%0d want 1/15/1", r_matches, r_pos, match_cnt);
    end
    total++; if (r_busy_gap !== 0) begin bad++; $display("FAIL busy_start_gap got=%0d want=0", r_busy_gap); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, idle_cnt;
    d1 = -1; d2 = -1; idle_cnt = 0;
    word = 16'hC000; nbits = 5'd2; start = 1'b1;
    @(posedge CLOCK_50); #1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (!busy && k <= 6) idle_cnt++;
    end
    start = 1'b0;
    total++; if (d1 !== 3 || d2 !== 7) begin bad++; $display("FAIL b2b_done_edges got=%0d,%0d want=3,7", d1, d2); end
    total++; if (idle_cnt !== 1) begin bad++; $display("FAIL b2b_idle_cycles got=%0d want=1", idle_cnt); end
    @(posedge CLOCK_50); #1;
    total++; if (busy !== 1'b0 || win !== 7'b0000011) begin
      bad++; $display("FAIL b2b_stop got busy=%b win=%b want 0/0000011", busy, win);
    end
  endtask

  task automatic test_reset_midrun;
    int seen_done;
    seen_done = 0;
    word = 16'hCF9C; nbits = 5'd16; start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    total++; if (win !== 7'b0011001 || busy !== 1'b1) begin
      bad++; $display("FAIL midrun_pre got win=%b busy=%b want 0011001/1", win, busy);
    end
    @(negedge CLOCK_50);
    RESET = 1'b1;
    #1;
    total++;
    if ({busy, done, match, bit_out, win, match_pos, match_cnt} !== '0) begin
      bad++;
      $display("FAIL midrun_async_clear got=%b want=0", {busy, done, match, bit_out, win, match_pos, match_cnt});
    end
    repeat (3) begin
      @(posedge CLOCK_50); #1;
      if (done || busy) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d want=0", seen_done); end
    @(negedge CLOCK_50);
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    do_run(16'h0067, 5'd16, -1);
    total++; if (r_lat !== 17 || r_pos !== 15 || match_cnt !== 4'd1) begin
      bad++; $display("FAIL midrun_recover got lat=%0d pos=%0d cnt=%0d want 17/15/1", r_lat, r_pos, match_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single_hit;
    test_overlap;
    test_boundaries;
    test_saturation;
    test_busy_start;
    test_back_to_back;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
